// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO on the peripheral bus: configurable frame
// format, back-to-back frames on tx and a status word on reads.

package uart_tx_fifo_pkg;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic        mem_error;
        logic [31:0] mem_rdata;
    } mem_out_type;

endpackage

module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int clock_rate = 868,
    parameter int data_bits  = 8,
    parameter int parity     = 0,
    parameter int stop_bits  = 1,
    parameter int depth      = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  uart_in,
    output mem_out_type uart_out,
    output logic        tx
);

    localparam int ptr_w_c = $clog2(depth);
    localparam int cnt_w_c = ptr_w_c + 1;
    localparam int bit_w_c = $clog2(clock_rate);

    localparam logic [bit_w_c-1:0] bit_last_c  = bit_w_c'(clock_rate - 1);
    localparam logic [2:0]         data_last_c = 3'(data_bits - 1);
    localparam logic [2:0]         stop_last_c = 3'(stop_bits - 1);
    localparam logic [cnt_w_c-1:0] depth_c     = cnt_w_c'(depth);
    localparam logic               parity_en_c = (parity != 0);
    localparam logic               parity_odd_c = (parity == 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic parity_bit(input logic [data_bits-1:0] d);
        if (parity_odd_c) begin
            parity_bit = ~(^d);
        end else begin
            parity_bit = ^d;
        end
    endfunction

    state_t                 state_r;
    logic [data_bits-1:0]   fifo_mem_r [depth];
    logic [ptr_w_c-1:0]     wr_ptr_r;
    logic [ptr_w_c-1:0]     rd_ptr_r;
    logic [cnt_w_c-1:0]     count_r;
    logic [bit_w_c-1:0]     bit_cnt_r;
    logic [2:0]             idx_r;
    logic [data_bits-1:0]   shift_r;
    logic                   par_r;
    logic                   tx_r;
    logic                   ready_r;
    logic                   error_r;
    logic [31:0]            rdata_r;

    logic                   wr_req_s;
    logic                   rd_req_s;
    logic                   full_s;
    logic                   empty_s;
    logic                   busy_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   bit_end_s;
    logic                   frame_end_s;
    logic                   tx_next_s;
    logic [data_bits-1:0]   head_s;
    logic [31:0]            status_s;
    logic                   unused_s;

    assign wr_req_s    = uart_in.mem_valid & (|uart_in.mem_wstrb);
    assign rd_req_s    = uart_in.mem_valid & ~(|uart_in.mem_wstrb);
    assign full_s      = (count_r == depth_c);
    assign empty_s     = (count_r == {cnt_w_c{1'b0}});
    assign busy_s      = (state_r != IDLE);
    assign bit_end_s   = (bit_cnt_r == bit_last_c);
    assign frame_end_s = (state_r == STOP) & bit_end_s & (idx_r == stop_last_c);
    // Fullness is judged on the registered count, so a same-cycle pop never rescues a write.
    assign push_s      = wr_req_s & ~full_s;
    assign pop_s       = ~empty_s & ((state_r == IDLE) | frame_end_s);
    assign head_s      = fifo_mem_r[rd_ptr_r];
    assign status_s    = {16'h0000, 8'(count_r), 5'b00000, busy_s, empty_s, full_s};
    assign unused_s    = ^{uart_in.mem_instr, uart_in.mem_addr, uart_in.mem_wdata};

    // Line level for the next cycle, derived from the current FSM state.
    always_comb begin
        tx_next_s = 1'b1;
        case (state_r)
            IDLE:    tx_next_s = 1'b1;
            START:   tx_next_s = 1'b0;
            DATA:    tx_next_s = shift_r[0];
            PARITY:  tx_next_s = par_r;
            STOP:    tx_next_s = 1'b1;
            default: tx_next_s = 1'b1;
        endcase
    end

    // FIFO storage write port.
    always_ff @(posedge clock) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= uart_in.mem_wdata[data_bits-1:0];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {ptr_w_c{1'b0}};
            rd_ptr_r <= {ptr_w_c{1'b0}};
            count_r  <= {cnt_w_c{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ptr_w_c'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ptr_w_c'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + cnt_w_c'(1);
                2'b01:   count_r <= count_r - cnt_w_c'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame sequencer; a frame end with data pending loads the next frame on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            bit_cnt_r <= {bit_w_c{1'b0}};
            idx_r     <= 3'd0;
            shift_r   <= {data_bits{1'b0}};
            par_r     <= 1'b0;
            tx_r      <= 1'b1;
        end else begin
            tx_r <= tx_next_s;
            case (state_r)
                IDLE: begin
                    if (!empty_s) begin
                        shift_r   <= head_s;
                        par_r     <= parity_bit(head_s);
                        bit_cnt_r <= {bit_w_c{1'b0}};
                        idx_r     <= 3'd0;
                        state_r   <= START;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        bit_cnt_r <= {bit_w_c{1'b0}};
                        idx_r     <= 3'd0;
                        state_r   <= DATA;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + bit_w_c'(1);
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        bit_cnt_r <= {bit_w_c{1'b0}};
                        shift_r   <= {1'b0, shift_r[data_bits-1:1]};
                        if (idx_r == data_last_c) begin
                            idx_r   <= 3'd0;
                            state_r <= parity_en_c ? PARITY : STOP;
                        end else begin
                            idx_r   <= idx_r + 3'd1;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + bit_w_c'(1);
                    end
                end
                PARITY: begin
                    if (bit_end_s) begin
                        bit_cnt_r <= {bit_w_c{1'b0}};
                        idx_r     <= 3'd0;
                        state_r   <= STOP;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + bit_w_c'(1);
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        bit_cnt_r <= {bit_w_c{1'b0}};
                        if (idx_r == stop_last_c) begin
                            idx_r <= 3'd0;
                            if (!empty_s) begin
                                shift_r <= head_s;
                                par_r   <= parity_bit(head_s);
                                state_r <= START;
                            end else begin
                                state_r <= IDLE;
                            end
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + bit_w_c'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    bit_cnt_r <= {bit_w_c{1'b0}};
                    idx_r     <= 3'd0;
                end
            endcase
        end
    end

    // Single-cycle bus response.
    always_ff @(posedge clock) begin
        if (reset) begin
            ready_r <= 1'b0;
            error_r <= 1'b0;
            rdata_r <= 32'h0000_0000;
        end else begin
            ready_r <= wr_req_s | rd_req_s;
            error_r <= wr_req_s & full_s;
            rdata_r <= rd_req_s ? status_s : 32'h0000_0000;
        end
    end

    assign uart_out.mem_ready = ready_r;
    assign uart_out.mem_error = error_r;
    assign uart_out.mem_rdata = rdata_r;
    assign tx                 = tx_r;

endmodule
